ahb2apb_bridge_param: RTL and testbench
=======================================

AHB2APB_BRIDGE_PARAM -- requirements
Module: ahb2apb_bridge_param

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: HADDR/PADDR width.
REQ-002 SHALL have parameter DATA_W, default 32 (32 or 64): data width.
REQ-003 SHALL have parameter NSLV, default 4 (power of 2, >=2): number of APB slaves.
REQ-004 SHALL have parameter SLV_AW, default 12: bits per slave window; slave index = HADDR[SLV_AW +: log2(NSLV)].
REQ-005 SHALL have parameter TIMEOUT, default 0: maximum ACCESS cycles before error; 0 disables.
REQ-006 SHALL have one clock and an asynchronous active-low reset: HCLK in 1, rising edge; HRESETn in 1, async assert, active-low.
REQ-007 SHALL have AHB inputs: HSEL 1, HADDR ADDR_W, HWDATA DATA_W, HWRITE 1, HSIZE 3, HTRANS 2, HPROT 4, HREADYIN 1.
REQ-008 SHALL have AHB outputs: HREADYOUT 1, HRDATA DATA_W, HRESP 1.
REQ-009 SHALL have APB outputs: PSEL NSLV (one-hot), PENABLE 1, PADDR ADDR_W, PWRITE 1, PWDATA DATA_W, PSTRB DATA_W/8, PPROT 3.
REQ-010 SHALL have APB inputs: PRDATA NSLV*DATA_W (slave i at [i*DATA_W +: DATA_W]), PREADY NSLV, PSLVERR NSLV.

Function
REQ-011 Valid transfer SHALL be HSEL & HREADYIN & HTRANS[1], sampled only in states IDLE, DONE and ERR2.
REQ-012 FSM states SHALL be IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-013 Transfer acceptance SHALL register HADDR, HWRITE, HSIZE, HPROT and the slave index.
REQ-014 Accepted write SHALL go ->WDATA (latch HWDATA into PWDATA) ->SETUP. Accepted read SHALL go directly ->SETUP.
REQ-015 Accepted transfer with HSIZE > log2(DATA_W/8) or HADDR misaligned to HSIZE SHALL go ->ERR1 with no APB access.
REQ-016 SETUP SHALL drive exactly one PSEL bit with PENABLE=0, then go ->ACCESS unconditionally.
REQ-017 ACCESS SHALL hold PSEL=1, PENABLE=1 and all P* signals stable while the selected PREADY=0.
REQ-018 ACCESS with selected PREADY=1 and PSLVERR=0 SHALL go ->DONE and register the selected PRDATA into HRDATA (reads only; HRDATA unchanged on writes).
REQ-019 ACCESS with selected PREADY=1 and PSLVERR=1 SHALL go ->ERR1.
REQ-020 With TIMEOUT>0, the TIMEOUT-th consecutive ACCESS cycle without PREADY SHALL go ->ERR1 and deassert PSEL/PENABLE; the counter SHALL clear on entering SETUP.
REQ-021 HREADYOUT SHALL be 1 in IDLE, DONE and ERR2; 0 in WDATA, SETUP, ACCESS and ERR1.
REQ-022 HRESP SHALL be 1 only in ERR1 and ERR2 (two-cycle AHB error response).
REQ-023 DONE and ERR2 SHALL go ->accepted path (REQ-014/015) on a valid transfer, else ->IDLE; back-to-back transfers SHALL need no idle cycle.
REQ-024 PSTRB SHALL be the byte lanes from HSIZE and HADDR low bits for writes, and all-zero for reads.
REQ-025 PPROT SHALL be {~HPROT[0], 1'b1, HPROT[1]}.
REQ-026 PADDR SHALL be the registered HADDR; PWRITE the registered HWRITE.
REQ-027 Non-valid transfers (IDLE/BUSY, HSEL=0) in IDLE SHALL get a zero-wait OKAY response and cause no state change.

Reset
REQ-028 HRESETn low SHALL immediately force IDLE and set HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, PPROT=0, and clear the timeout counter, including mid-transfer.
REQ-029 The first transfer SHALL be acceptable on the first HCLK edge after HRESETn deasserts.

Structure
REQ-030 Package ahb2apb_pkg SHALL hold the state enum, the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and the HSIZE constants.
REQ-031 Sub-module apb_slave_mux SHALL select PRDATA/PREADY/PSLVERR by the registered slave index.

Verification
REQ-032 Read HADDR=0x0000_1004, NSLV=4, slave 1 PREADY=1 -> PSEL=4'b0010, PADDR=0x1004, PSTRB=0; HRDATA=0xCAFE_F00D; HREADYOUT low 2 cycles.
REQ-033 Write HADDR=0x3008, HWDATA=0xA5A5_A5A5, HSIZE=2, slave 3 with 2 PREADY wait cycles -> PWDATA=0xA5A5_A5A5, PSTRB=4'hF, P* stable for 3 ACCESS cycles.
REQ-034 Byte write HADDR=0x0002, HSIZE=0 -> PSTRB=4'b0100. Halfword HADDR=0x0001 -> ERR1/ERR2, no PSEL asserted.
REQ-035 PSLVERR=1 on slave 2 -> HRESP=1 two cycles (HREADYOUT 0 then 1); NONSEQ read issued during ERR2 completes normally.
REQ-036 TIMEOUT=8, PREADY held 0 -> PSEL drops after 8 ACCESS cycles, error response. HRESETn pulsed mid-ACCESS -> all outputs at reset values.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// ============================================================================
// Package  : ahb2apb_pkg
// Brief    : Shared types and constants for the AHB-to-APB bridge: FSM state
//            encoding, AHB HTRANS/HSIZE encodings and an alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb2apb_pkg;

   // Bridge FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR1   = 3'd5,
      ST_ERR2   = 3'd6
   } state_t;

   // AHB HTRANS encodings
   localparam logic [1:0] c_htrans_idle   = 2'b00;
   localparam logic [1:0] c_htrans_busy   = 2'b01;
   localparam logic [1:0] c_htrans_nonseq = 2'b10;
   localparam logic [1:0] c_htrans_seq    = 2'b11;

   // AHB HSIZE encodings
   localparam logic [2:0] c_hsize_byte  = 3'd0;
   localparam logic [2:0] c_hsize_half  = 3'd1;
   localparam logic [2:0] c_hsize_word  = 3'd2;
   localparam logic [2:0] c_hsize_dword = 3'd3;

   // Low address bits that must be zero for a transfer of the given size
   function automatic logic [2:0] align_mask(input logic [2:0] size);
      logic [2:0] m;
      case (size)
         c_hsize_byte : m = 3'b000;
         c_hsize_half : m = 3'b001;
         c_hsize_word : m = 3'b011;
         default      : m = 3'b111;
      endcase
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_slave_mux.sv
// ============================================================================
// Module   : apb_slave_mux
// Brief    : Selects the addressed APB slave's PRDATA/PREADY/PSLVERR using the
//            slave index captured when the transfer was accepted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mux
   import ahb2apb_pkg::*;
#(
   parameter int NSLV   = 4,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 2
) (
   input  logic [IDX_W-1:0]       i_idx,
   input  logic [NSLV*DATA_W-1:0] i_prdata,
   input  logic [NSLV-1:0]        i_pready,
   input  logic [NSLV-1:0]        i_pslverr,
   output logic [DATA_W-1:0]      o_prdata,
   output logic                   o_pready,
   output logic                   o_pslverr
);

   // Slave i occupies PRDATA[i*DATA_W +: DATA_W]
   assign o_prdata  = i_prdata[i_idx*DATA_W +: DATA_W];
   assign o_pready  = i_pready[i_idx];
   assign o_pslverr = i_pslverr[i_idx];

endmodule

`default_nettype wire

// File: rtl/ahb2apb_bridge_param.sv
// ============================================================================
// Module   : ahb2apb_bridge_param
// Brief    : Parameterised AHB-Lite to APB bridge with one-hot slave decode,
//            size/alignment checking, two-cycle AHB error response and an
//            optional ACCESS-phase timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb2apb_bridge_param
   import ahb2apb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NSLV    = 4,
   parameter int SLV_AW  = 12,
   parameter int TIMEOUT = 0
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   // AHB slave side
   input  logic                   HSEL,
   input  logic [ADDR_W-1:0]      HADDR,
   input  logic [DATA_W-1:0]      HWDATA,
   input  logic                   HWRITE,
   input  logic [2:0]             HSIZE,
   input  logic [1:0]             HTRANS,
   input  logic [3:0]             HPROT,
   input  logic                   HREADYIN,
   output logic                   HREADYOUT,
   output logic [DATA_W-1:0]      HRDATA,
   output logic                   HRESP,
   // APB master side
   output logic [NSLV-1:0]        PSEL,
   output logic                   PENABLE,
   output logic [ADDR_W-1:0]      PADDR,
   output logic                   PWRITE,
   output logic [DATA_W-1:0]      PWDATA,
   output logic [DATA_W/8-1:0]    PSTRB,
   output logic [2:0]             PPROT,
   input  logic [NSLV*DATA_W-1:0] PRDATA,
   input  logic [NSLV-1:0]        PREADY,
   input  logic [NSLV-1:0]        PSLVERR
);

   localparam int c_nb       = DATA_W / 8;
   localparam int c_ow       = $clog2(c_nb);
   localparam int c_max_size = $clog2(c_nb);
   localparam int c_iw       = $clog2(NSLV);
   localparam int c_tw       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [c_tw-1:0] c_tlim = c_tw'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [NSLV-1:0] c_one  = NSLV'(1);

   state_t            r_state;
   logic [c_iw-1:0]   r_idx;
   logic [c_tw-1:0]   r_cnt;

   logic              w_valid;
   logic              w_accept;
   logic              w_bad;
   logic [c_iw-1:0]   w_idx;
   logic [c_nb-1:0]   w_strb;
   logic [DATA_W-1:0] w_prdata;
   logic              w_pready;
   logic              w_pslverr;
   logic              w_timeout;
   logic              w_unused;

   // Transfers are only sampled when the bridge is presenting HREADYOUT=1
   assign w_valid   = HSEL & HREADYIN & HTRANS[1];
   assign w_accept  = w_valid & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERR2));
   assign w_bad     = (HSIZE > 3'(c_max_size)) | (|(HADDR[2:0] & align_mask(HSIZE)));
   assign w_idx     = HADDR[SLV_AW +: c_iw];
   assign w_timeout = (TIMEOUT > 0) && (r_cnt == c_tlim);
   assign w_unused  = ^{HPROT[3:2], HTRANS[0]};

   // Byte lane i is active when it lies in the same naturally aligned chunk as HADDR
   always_comb begin
      w_strb = '0;
      for (int i = 0; i < c_nb; i++) begin
         w_strb[i] = ((i >> HSIZE) == (int'(HADDR[c_ow-1:0]) >> HSIZE));
      end
   end

   apb_slave_mux #(
      .NSLV   (NSLV),
      .DATA_W (DATA_W),
      .IDX_W  (c_iw)
   ) u_mux (
      .i_idx     (r_idx),
      .i_prdata  (PRDATA),
      .i_pready  (PREADY),
      .i_pslverr (PSLVERR),
      .o_prdata  (w_prdata),
      .o_pready  (w_pready),
      .o_pslverr (w_pslverr)
   );

   // Bridge FSM with all AHB/APB outputs registered alongside the state
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_cnt     <= '0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         PPROT     <= '0;
      end else if (w_accept) begin
         r_idx     <= w_idx;
         r_cnt     <= '0;
         PADDR     <= HADDR;
         PWRITE    <= HWRITE;
         PPROT     <= {~HPROT[0], 1'b1, HPROT[1]};
         PSTRB     <= HWRITE ? w_strb : '0;
         PENABLE   <= 1'b0;
         HREADYOUT <= 1'b0;
         if (w_bad) begin
            // Illegal size or alignment: answer with an error, never touch APB
            r_state <= ST_ERR1;
            HRESP   <= 1'b1;
            PSEL    <= '0;
         end else if (HWRITE) begin
            // Write data arrives one cycle later, in the AHB data phase
            r_state <= ST_WDATA;
            HRESP   <= 1'b0;
            PSEL    <= '0;
         end else begin
            r_state <= ST_SETUP;
            HRESP   <= 1'b0;
            PSEL    <= c_one << w_idx;
         end
      end else begin
         case (r_state)
            ST_WDATA: begin
               PWDATA  <= HWDATA;
               PSEL    <= c_one << r_idx;
               r_cnt   <= '0;
               r_state <= ST_SETUP;
            end
            ST_SETUP: begin
               PENABLE <= 1'b1;
               r_state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (w_pready) begin
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  if (w_pslverr) begin
                     r_state <= ST_ERR1;
                     HRESP   <= 1'b1;
                  end else begin
                     r_state   <= ST_DONE;
                     HREADYOUT <= 1'b1;
                     if (!PWRITE) begin
                        HRDATA <= w_prdata;
                     end
                  end
               end else if (w_timeout) begin
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  r_state <= ST_ERR1;
                  HRESP   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_ERR1: begin
               r_state   <= ST_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b1;
            end
            default: begin
               // IDLE, DONE or ERR2 with no valid transfer offered
               r_state   <= ST_IDLE;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b0;
               PSEL      <= '0;
               PENABLE   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb2apb_bridge_param.sv
// ============================================================================
// Module   : tb_ahb2apb_bridge_param
// Brief    : Directed self-checking bench for ahb2apb_bridge_param
//            (NSLV=4, DATA_W=32, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb2apb_bridge_param;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int NSLV    = 4;
   localparam int SLV_AW  = 12;
   localparam int TIMEOUT = 8;

   logic                   HCLK = 1'b0;
   logic                   HRESETn;
   logic                   HSEL;
   logic [ADDR_W-1:0]      HADDR;
   logic [DATA_W-1:0]      HWDATA;
   logic                   HWRITE;
   logic [2:0]             HSIZE;
   logic [1:0]             HTRANS;
   logic [3:0]             HPROT;
   logic                   HREADYIN;
   logic                   HREADYOUT;
   logic [DATA_W-1:0]      HRDATA;
   logic                   HRESP;
   logic [NSLV-1:0]        PSEL;
   logic                   PENABLE;
   logic [ADDR_W-1:0]      PADDR;
   logic                   PWRITE;
   logic [DATA_W-1:0]      PWDATA;
   logic [DATA_W/8-1:0]    PSTRB;
   logic [2:0]             PPROT;
   logic [NSLV*DATA_W-1:0] PRDATA;
   logic [NSLV-1:0]        PREADY;
   logic [NSLV-1:0]        PSLVERR;

   int n_cmp = 0;
   int n_bad = 0;

   ahb2apb_bridge_param #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .NSLV    (NSLV),
      .SLV_AW  (SLV_AW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HTRANS    (HTRANS),
      .HPROT     (HPROT),
      .HREADYIN  (HREADYIN),
      .HREADYOUT (HREADYOUT),
      .HRDATA    (HRDATA),
      .HRESP     (HRESP),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PADDR     (PADDR),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PSTRB     (PSTRB),
      .PPROT     (PPROT),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HADDR  = '0;
      HSIZE  = 3'd0;
   endtask

   task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz);
      HSEL     = 1'b1;
      HADDR    = a;
      HWRITE   = w;
      HSIZE    = sz;
      HTRANS   = 2'b10;
      HPROT    = 4'b0011;
      HREADYIN = 1'b1;
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_hreadyout"}, 64'(HREADYOUT), 64'd1);
      chk({pfx, "_hresp"},     64'(HRESP),     64'd0);
      chk({pfx, "_hrdata"},    64'(HRDATA),    64'd0);
      chk({pfx, "_psel"},      64'(PSEL),      64'd0);
      chk({pfx, "_penable"},   64'(PENABLE),   64'd0);
      chk({pfx, "_paddr"},     64'(PADDR),     64'd0);
      chk({pfx, "_pwrite"},    64'(PWRITE),    64'd0);
      chk({pfx, "_pwdata"},    64'(PWDATA),    64'd0);
      chk({pfx, "_pstrb"},     64'(PSTRB),     64'd0);
      chk({pfx, "_pprot"},     64'(PPROT),     64'd0);
   endtask

   // Bound on total run time
   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      HRESETn  = 1'b0;
      bus_idle();
      HREADYIN = 1'b1;
      HPROT    = 4'b0000;
      HWDATA   = '0;
      PREADY   = 4'hF;
      PSLVERR  = 4'h0;
      PRDATA   = '0;
      PRDATA[0*32 +: 32] = 32'h1234_5678;
      PRDATA[1*32 +: 32] = 32'hCAFE_F00D;
      PRDATA[2*32 +: 32] = 32'h0BAD_BEEF;
      PRDATA[3*32 +: 32] = 32'hDEAD_BEEF;

      // ---- reset values
      #12;
      chk_reset_vals("rst");

      // ---- read slave 1, first edge after reset release
      step();
      HRESETn = 1'b1;
      issue(32'h0000_1004, 1'b0, 3'd2);
      step();                                   // SETUP
      bus_idle();
      chk("rd_setup_psel",   64'(PSEL),      64'h2);
      chk("rd_setup_pen",    64'(PENABLE),   64'd0);
      chk("rd_setup_paddr",  64'(PADDR),     64'h1004);
      chk("rd_setup_pstrb",  64'(PSTRB),     64'h0);
      chk("rd_setup_pwrite", 64'(PWRITE),    64'd0);
      chk("rd_setup_pprot",  64'(PPROT),     64'b011);
      chk("rd_setup_hrdy",   64'(HREADYOUT), 64'd0);
      step();                                   // ACCESS
      chk("rd_acc_psel",     64'(PSEL),      64'h2);
      chk("rd_acc_pen",      64'(PENABLE),   64'd1);
      chk("rd_acc_hrdy",     64'(HREADYOUT), 64'd0);
      step();                                   // DONE
      chk("rd_done_hrdy",    64'(HREADYOUT), 64'd1);
      chk("rd_done_hrdata",  64'(HRDATA),    64'hCAFE_F00D);
      chk("rd_done_psel",    64'(PSEL),      64'h0);
      chk("rd_done_hresp",   64'(HRESP),     64'd0);
      step();                                   // IDLE

      // ---- BUSY transfer in IDLE: zero-wait OKAY, nothing started
      HSEL   = 1'b1;
      HTRANS = 2'b01;
      step();
      chk("busy_hrdy",       64'(HREADYOUT), 64'd1);
      chk("busy_psel",       64'(PSEL),      64'h0);
      chk("busy_hresp",      64'(HRESP),     64'd0);
      bus_idle();

      // ---- word write to slave 3 with two wait cycles
      PREADY[3] = 1'b0;
      issue(32'h0000_3008, 1'b1, 3'd2);
      step();                                   // WDATA
      chk("wr_wdata_hrdy",   64'(HREADYOUT), 64'd0);
      chk("wr_wdata_psel",   64'(PSEL),      64'h0);
      HWDATA = 32'hA5A5_A5A5;
      bus_idle();
      step();                                   // SETUP
      chk("wr_setup_pwdata", 64'(PWDATA),    64'hA5A5_A5A5);
      chk("wr_setup_psel",   64'(PSEL),      64'h8);
      chk("wr_setup_pen",    64'(PENABLE),   64'd0);
      chk("wr_setup_pstrb",  64'(PSTRB),     64'hF);
      chk("wr_setup_pwrite", 64'(PWRITE),    64'd1);
      HWDATA = 32'h0;
      for (int k = 0; k < 3; k++) begin
         step();                                // ACCESS cycle k+1
         chk("wr_acc_psel",   64'(PSEL),      64'h8);
         chk("wr_acc_pen",    64'(PENABLE),   64'd1);
         chk("wr_acc_paddr",  64'(PADDR),     64'h3008);
         chk("wr_acc_pwdata", 64'(PWDATA),    64'hA5A5_A5A5);
         chk("wr_acc_pstrb",  64'(PSTRB),     64'hF);
         chk("wr_acc_hrdy",   64'(HREADYOUT), 64'd0);
         if (k == 2) PREADY[3] = 1'b1;
      end
      step();                                   // DONE
      chk("wr_done_hrdy",    64'(HREADYOUT), 64'd1);
      chk("wr_done_hrdata",  64'(HRDATA),    64'hCAFE_F00D);
      chk("wr_done_psel",    64'(PSEL),      64'h0);

      // ---- byte write issued back-to-back from DONE
      issue(32'h0000_0002, 1'b1, 3'd0);
      step();                                   // WDATA
      chk("bw_wdata_hrdy",   64'(HREADYOUT), 64'd0);
      HWDATA = 32'h1122_3344;
      bus_idle();
      step();                                   // SETUP
      chk("bw_pstrb",        64'(PSTRB),     64'b0100);
      chk("bw_psel",         64'(PSEL),      64'h1);
      chk("bw_pwdata",       64'(PWDATA),    64'h1122_3344);
      step();                                   // ACCESS
      step();                                   // DONE
      chk("bw_done_hrdy",    64'(HREADYOUT), 64'd1);

      // ---- misaligned halfword, back-to-back from DONE
      issue(32'h0000_0001, 1'b1, 3'd1);
      step();                                   // ERR1
      bus_idle();
      chk("mis_err1_hresp",  64'(HRESP),     64'd1);
      chk("mis_err1_hrdy",   64'(HREADYOUT), 64'd0);
      chk("mis_err1_psel",   64'(PSEL),      64'h0);
      step();                                   // ERR2
      chk("mis_err2_hresp",  64'(HRESP),     64'd1);
      chk("mis_err2_hrdy",   64'(HREADYOUT), 64'd1);
      chk("mis_err2_psel",   64'(PSEL),      64'h0);
      chk("mis_err2_pen",    64'(PENABLE),   64'd0);
      step();                                   // IDLE
      chk("mis_idle_hresp",  64'(HRESP),     64'd0);

      // ---- slave error on slave 2, then read issued during ERR2
      PSLVERR[2] = 1'b1;
      issue(32'h0000_2000, 1'b0, 3'd2);
      step();                                   // SETUP
      bus_idle();
      chk("se_setup_psel",   64'(PSEL),      64'h4);
      step();                                   // ACCESS
      step();                                   // ERR1
      chk("se_err1_hresp",   64'(HRESP),     64'd1);
      chk("se_err1_hrdy",    64'(HREADYOUT), 64'd0);
      chk("se_err1_psel",    64'(PSEL),      64'h0);
      chk("se_err1_hrdata",  64'(HRDATA),    64'hCAFE_F00D);
      step();                                   // ERR2
      chk("se_err2_hresp",   64'(HRESP),     64'd1);
      chk("se_err2_hrdy",    64'(HREADYOUT), 64'd1);
      PSLVERR[2] = 1'b0;
      issue(32'h0000_0010, 1'b0, 3'd2);
      step();                                   // SETUP
      bus_idle();
      chk("se_nx_hresp",     64'(HRESP),     64'd0);
      chk("se_nx_hrdy",      64'(HREADYOUT), 64'd0);
      chk("se_nx_psel",      64'(PSEL),      64'h1);
      chk("se_nx_paddr",     64'(PADDR),     64'h10);
      step();                                   // ACCESS
      step();                                   // DONE
      chk("se_nx_hrdata",    64'(HRDATA),    64'h1234_5678);
      chk("se_nx_done_resp", 64'(HRESP),     64'd0);
      chk("se_nx_done_hrdy", 64'(HREADYOUT), 64'd1);

      // ---- timeout: slave 1 never ready
      PREADY[1] = 1'b0;
      issue(32'h0000_1000, 1'b0, 3'd2);
      step();                                   // SETUP
      bus_idle();
      for (int k = 0; k < 8; k++) begin
         step();                                // ACCESS cycle k+1
         chk("to_acc_psel_pen", 64'({PSEL, PENABLE}), 64'b00101);
      end
      step();                                   // ERR1
      chk("to_err1_psel",    64'(PSEL),      64'h0);
      chk("to_err1_pen",     64'(PENABLE),   64'd0);
      chk("to_err1_hresp",   64'(HRESP),     64'd1);
      chk("to_err1_hrdy",    64'(HREADYOUT), 64'd0);
      step();                                   // ERR2
      chk("to_err2_hresp",   64'(HRESP),     64'd1);
      chk("to_err2_hrdy",    64'(HREADYOUT), 64'd1);
      step();                                   // IDLE
      PREADY[1] = 1'b1;

      // ---- asynchronous reset in the middle of an ACCESS phase
      PREADY[3] = 1'b0;
      issue(32'h0000_3004, 1'b1, 3'd2);
      step();                                   // WDATA
      HWDATA = 32'h5A5A_5A5A;
      bus_idle();
      step();                                   // SETUP
      step();                                   // ACCESS 1
      step();                                   // ACCESS 2
      chk("mr_pre_pen",      64'(PENABLE),   64'd1);
      #2;
      HRESETn = 1'b0;
      #1;
      chk_reset_vals("mr");

      // ---- recovery read after reset
      step();
      HRESETn = 1'b1;
      PREADY  = 4'hF;
      issue(32'h0000_1004, 1'b0, 3'd2);
      step();                                   // SETUP
      bus_idle();
      step();                                   // ACCESS
      step();                                   // DONE
      chk("rec_hrdata",      64'(HRDATA),    64'hCAFE_F00D);
      chk("rec_hrdy",        64'(HREADYOUT), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
